// File: rtl/dsp_real_from_sint.sv
// Sequential signed-integer to IEEE-754 double converter with ready/valid handshakes.
// Each word is normalised by a binary-search shifter over NSTAGES cycles, then rounded to nearest even.
module dsp_real_from_sint #(
    parameter int IN_WIDTH = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_in_valid,
    output logic                io_in_ready,
    input  logic [IN_WIDTH-1:0] io_in_bits,
    output logic                io_out_valid,
    input  logic                io_out_ready,
    output logic [63:0]         io_out_node
);

    localparam int W       = IN_WIDTH;
    localparam int NSTAGES = $clog2(IN_WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NORM  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]         state;
    logic               sign;
    logic               zero;
    logic [W-1:0]       mag;
    logic [NSTAGES-1:0] shift;
    logic [NSTAGES-1:0] stage;

    logic [NSTAGES-1:0] step;
    logic [W-1:0]       top_mask;
    logic               top_clear;

    logic [W+52:0]      ext;
    logic [51:0]        frac;
    logic               g;
    logic               st;
    logic               rnd;
    logic [52:0]        sum;
    logic [10:0]        exp_base;
    logic [10:0]        exp_final;

    always_comb begin
        step      = NSTAGES'(1) << stage;
        top_mask  = ~({W{1'b1}} >> step);
        top_clear = (mag & top_mask) == '0;
    end

    // ext places mag bit j at index j+54, so missing low bits read as zero padding for narrow inputs.
    always_comb begin
        ext       = {mag[W-2:0], 54'b0};
        frac      = ext[W+52 -: 52];
        g         = ext[W];
        st        = |ext[W-1:0];
        rnd       = g & (st | frac[0]);
        sum       = {1'b0, frac} + 53'(rnd);
        exp_base  = 11'(1023 + W - 1) - 11'(shift);
        exp_final = sum[52] ? exp_base + 11'd1 : exp_base;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            sign        <= 1'b0;
            zero        <= 1'b0;
            mag         <= '0;
            shift       <= '0;
            stage       <= '0;
            io_out_node <= 64'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_in_valid) begin
                        sign  <= io_in_bits[W-1];
                        mag   <= io_in_bits[W-1] ? -io_in_bits : io_in_bits;
                        zero  <= (io_in_bits == '0);
                        shift <= '0;
                        stage <= NSTAGES'(NSTAGES - 1);
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (top_clear) begin
                        mag   <= mag << step;
                        shift <= shift + step;
                    end
                    if (stage == '0) begin
                        state <= ROUND;
                    end else begin
                        stage <= stage - NSTAGES'(1);
                    end
                end
                ROUND: begin
                    io_out_node <= zero ? 64'h0 : {sign, exp_final, sum[51:0]};
                    state       <= DONE;
                end
                DONE: begin
                    if (io_out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io_in_ready  = (state == IDLE);
    assign io_out_valid = (state == DONE);

endmodule
